gray_seq_ctrl: RTL and testbench

Command-driven sequencer for a WIDTH-bit Gray position counter. It accepts a move command (target, direction, step interval) over a valid/ready handshake. It then steps the Gray counter one code at a time, with wrap, until the position equals the target, and signals completion. It sits between a control master and any consumer of single-bit-change position codes, such as encoders, pointer logic or stepper phase drive.

---
 rtl/gray_seq_ctrl_pkg.sv | 18 +
 rtl/gray_seq_ctrl_tick_gen.sv | 46 ++++
 rtl/gray_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_gray_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_seq_ctrl_pkg.sv
// Shared types and helpers for the Gray position sequencer.
package gray_seq_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reflected binary Gray code of a binary value; callers cast to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] x);
        return x ^ (x >> 1);
    endfunction

endpackage

// File: rtl/gray_seq_ctrl_tick_gen.sv
// Step-interval prescaler: loaded on command accept, counts down while enabled,
// and reloads with the captured interval every time it hits zero.
module gray_tick_gen
    import gray_seq_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             enable,
    input  logic [DIV_W-1:0] reload_val,
    output logic             tick
);

    logic [DIV_W-1:0] presc_q;
    logic [DIV_W-1:0] presc_d;

    // A tick is due whenever the count has run out while the sequencer is moving.
    assign tick = enable && (presc_q == '0);

    // Next count: a fresh load wins, otherwise reload on zero or count down.
    always_comb begin
        presc_d = presc_q;
        if (load) begin
            presc_d = load_val;
        end else if (enable) begin
            if (presc_q == '0) begin
                presc_d = reload_val;
            end else begin
                presc_d = presc_q - {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command-driven sequencer that walks a Gray position counter one code at a
// time towards a target, in a fixed direction, at a programmable step rate.
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic [WIDTH-1:0] gray,
    output logic             busy,
    output logic             step,
    output logic             done,
    output logic             aborted
);

    localparam logic [WIDTH-1:0] POS_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pos_q, pos_d;
    logic [WIDTH-1:0]   gray_q, gray_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic               dir_q, dir_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               step_q, step_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               presc_load;
    logic               tick;

    gray_tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (presc_load),
        .load_val   (cmd_div),
        .enable     (state_q == RUN),
        .reload_val (div_q),
        .tick       (tick)
    );

    // Sequencer decisions: accept, step, finish or abort, plus next outputs.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        target_d   = target_q;
        dir_d      = dir_q;
        div_d      = div_q;
        step_d     = 1'b0;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        presc_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    target_d   = cmd_target;
                    dir_d      = cmd_dir;
                    div_d      = cmd_div;
                    presc_load = 1'b1;
                    if (cmd_target == pos_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (tick) begin
                    pos_d  = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
                    step_d = 1'b1;
                    if (pos_d == target_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        gray_d      = WIDTH'(bin2gray(32'(pos_d)));
        busy_d      = (state_d == RUN);
        cmd_ready_d = (state_d == IDLE);
    end

    // State, position and registered outputs; reset discards any move in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            gray_q      <= '0;
            target_q    <= '0;
            dir_q       <= 1'b0;
            div_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            gray_q      <= gray_d;
            target_q    <= target_d;
            dir_q       <= dir_d;
            div_q       <= div_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            step_q      <= step_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign gray      = gray_q;
    assign busy      = busy_q;
    assign step      = step_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Testbench for gray_seq_ctrl: directed move table, reset corner cases and
// random moves, all checked cycle by cycle against a timeline model.
module tb_gray_seq_ctrl;

    localparam int W  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_target;
    logic          cmd_dir;
    logic [DW-1:0] cmd_div;
    logic          abort;
    logic [W-1:0]  gray;
    logic          busy;
    logic          step;
    logic          done;
    logic          aborted;

    int n_vec = 0;
    int n_bad = 0;
    int model_pos = 0;

    typedef struct {
        int         target;
        int         dir;
        int         div;
        int         abort_at;
        logic [3:0] exp_gray;
        logic       exp_aborted;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    gray_seq_ctrl #(
        .WIDTH(W),
        .DIV_W(DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_dir    (cmd_dir),
        .cmd_div    (cmd_div),
        .abort      (abort),
        .gray       (gray),
        .busy       (busy),
        .step       (step),
        .done       (done),
        .aborted    (aborted)
    );

    // Gray code of a position, straight from the definition.
    function automatic logic [3:0] to_gray(input int p);
        logic [3:0] b;
        b = p[3:0];
        return b ^ (b >> 1);
    endfunction

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hold reset low for a number of edges and check the quiet outputs each cycle.
    task automatic resetDut(input int cycles);
        reset = 1'b0;
        cmd_valid = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput("rst_gray", gray, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_step", step, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_aborted", aborted, 0);
            checkOutput("rst_ready", cmd_ready, 1);
        end
        reset = 1'b1;
        model_pos = 0;
    endtask

    // Issue one move and check every cycle from accept to the return to IDLE.
    // Timeline c counts cycles after the accept edge; the move ends at edge T.
    task automatic applyStimulus(input int target, input int dir, input int div,
                                 input int abort_at, input bit noisy,
                                 output logic got_aborted);
        int per, n, t_end, s_end, s, s_prev, p;
        bit is_ab;
        logic [3:0] prev_g;
        per    = div + 1;
        n      = dir != 0 ? ((target - model_pos) & 15) : ((model_pos - target) & 15);
        is_ab  = (abort_at >= 0) && (abort_at < n * per);
        t_end  = is_ab ? abort_at + 1 : n * per;
        s_end  = is_ab ? abort_at / per : n;
        got_aborted = 1'b0;
        @(negedge clk);
        checkOutput("ready_before_cmd", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_target = target[3:0];
        cmd_dir    = dir[0];
        cmd_div    = div[7:0];
        abort      = 1'b0;
        @(negedge clk);
        prev_g = to_gray(model_pos);
        s_prev = 0;
        for (int c = 0; c <= t_end + 1; c++) begin
            s = (c < t_end) ? c / per : s_end;
            p = dir != 0 ? ((model_pos + s) & 15) : ((model_pos + 16 - s) & 15);
            checkOutput("gray", gray, to_gray(p));
            checkOutput("busy", busy, (c < t_end) && (n > 0));
            checkOutput("done", done, c == t_end);
            checkOutput("aborted", aborted, (c == t_end) && is_ab);
            checkOutput("step", step, (c > 0) && (s != s_prev));
            checkOutput("cmd_ready", cmd_ready, c > t_end);
            if (c > 0 && gray !== prev_g) begin
                checkOutput("one_bit_change", $countones(gray ^ prev_g), 1);
            end
            if (c == t_end) begin
                got_aborted = aborted;
            end
            prev_g = gray;
            s_prev = s;
            abort = is_ab && (c == abort_at);
            if (noisy) begin
                cmd_valid  = (c < t_end) ? 1'($urandom_range(0, 1)) : 1'b0;
                cmd_target = 4'($urandom);
                if (c >= t_end) begin
                    abort = 1'($urandom_range(0, 1));
                end
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        model_pos = dir != 0 ? ((model_pos + s_end) & 15) : ((model_pos + 16 - s_end) & 15);
    endtask

    initial begin
        logic ab;
        int tgt, dr, dv, at;

        tbl[0] = '{target: 5,  dir: 1, div: 0, abort_at: -1, exp_gray: 4'b0111, exp_aborted: 1'b0};
        tbl[1] = '{target: 3,  dir: 0, div: 2, abort_at: -1, exp_gray: 4'b0010, exp_aborted: 1'b0};
        tbl[2] = '{target: 14, dir: 1, div: 0, abort_at: -1, exp_gray: 4'b1001, exp_aborted: 1'b0};
        tbl[3] = '{target: 1,  dir: 1, div: 0, abort_at: -1, exp_gray: 4'b0001, exp_aborted: 1'b0};
        tbl[4] = '{target: 5,  dir: 1, div: 1, abort_at: -1, exp_gray: 4'b0111, exp_aborted: 1'b0};
        tbl[5] = '{target: 5,  dir: 0, div: 7, abort_at: -1, exp_gray: 4'b0111, exp_aborted: 1'b0};
        tbl[6] = '{target: 0,  dir: 0, div: 0, abort_at: -1, exp_gray: 4'b0000, exp_aborted: 1'b0};
        tbl[7] = '{target: 8,  dir: 1, div: 3, abort_at: 11, exp_gray: 4'b0011, exp_aborted: 1'b1};

        cmd_valid  = 1'b0;
        cmd_target = '0;
        cmd_dir    = 1'b0;
        cmd_div    = '0;
        abort      = 1'b0;

        $display("[TB] reset for 3 cycles");
        resetDut(3);
        @(negedge clk);
        checkOutput("post_rst_ready", cmd_ready, 1);
        checkOutput("post_rst_gray", gray, 0);

        $display("[TB] directed move table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].target, tbl[i].dir, tbl[i].div, tbl[i].abort_at, 1'b0, ab);
            checkOutput("tbl_final_gray", gray, tbl[i].exp_gray);
            checkOutput("tbl_end_aborted", ab, tbl[i].exp_aborted);
        end

        $display("[TB] reset in the middle of a move");
        resetDut(2);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_target = 4'd8;
        cmd_dir    = 1'b1;
        cmd_div    = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("mid_busy", busy, 1);
        checkOutput("mid_gray", gray, to_gray(1));
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_gray", gray, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_step", step, 0);
        checkOutput("midrst_ready", cmd_ready, 1);
        reset = 1'b1;
        model_pos = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("after_rst_done", done, 0);
            checkOutput("after_rst_ready", cmd_ready, 1);
            checkOutput("after_rst_gray", gray, 0);
        end

        $display("[TB] random moves");
        for (int i = 0; i < 40; i++) begin
            tgt = int'($urandom_range(0, 15));
            dr  = int'($urandom_range(0, 1));
            dv  = int'($urandom_range(0, 3));
            at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            applyStimulus(tgt, dr, dv, at, 1'b1, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
